arb_rr_8: RTL

ARB_RR_8 -- requirements
Module: arb_rr_8

---
 rtl/arb_rr_8_pkg.sv | 17 +
 rtl/arb_rr_8_dcd.sv | 17 +
 rtl/arb_rr_8.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arb_rr_8_pkg.sv
// arb_rr_8_pkg -- shared constants for the 8-way round-robin arbiter.
//   NREQ      : number of requesters (8)
//   IDXW      : width of a requester index (3)
//   ST_IDLE / ST_GRANT : FSM state encoding (0 / 1)
//   LAST_RST  : value of the round-robin pointer after reset (7), so that
//               requester 0 is searched first.
package arb_rr_8_pkg;

   localparam int NREQ = 8;
   localparam int IDXW = 3;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [IDXW-1:0] LAST_RST = 3'd7;

endpackage

// File: rtl/arb_rr_8_dcd.sv
// dcd_3_to_8 -- 3-to-8 one-hot decoder with enable.
//   idx  : binary index
//   en   : when low, output is all-zero
//   dout : one-hot decode of idx, gated by en
module dcd_3_to_8
   import arb_rr_8_pkg::*;
(
   input  logic [IDXW-1:0] idx,
   input  logic            en,
   output logic [NREQ-1:0] dout
);

   for (genvar i = 0; i < NREQ; i++) begin : g_dec
      assign dout[i] = en && (idx == IDXW'(i));
   end

endmodule

// File: rtl/arb_rr_8.sv
// arb_rr_8 -- 8-way round-robin arbiter with hold-until-release grants.
//   clk      : clock, all state updates on rising edge
//   rst      : synchronous active-high reset
//   req[7:0] : level request lines, held until served
//   done     : one-cycle release pulse from the current owner
//   gnt[7:0] : one-hot grant (zero when no owner)
//   gnt_idx  : binary index of the current owner
//   gnt_vld  : high while a grant is held
//   timeout  : one-cycle pulse when a grant is force-released
// Optional feature: define ARB_RR_8_TIMEOUT_EN to enable the hold counter,
// which force-releases a grant after MAX_HOLD GRANT cycles. Without it the
// timeout output is tied low and grants are held indefinitely.
module arb_rr_8
   import arb_rr_8_pkg::*;
#(
   parameter int MAX_HOLD = 15
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_vld,
   output logic            timeout
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("arb_rr_8: MAX_HOLD must be in 1..255");
   end

   logic [0:0]      state;
   logic [IDXW-1:0] last;
   logic [IDXW-1:0] pick_idx;
   logic [IDXW-1:0] cand;
   logic            pick_vld;
   logic            rel_norm;
   logic            hold_exp;
   logic            rel;

   // Search upward from last+1, wrapping; the 3-bit add does the mod 8.
   // The just-served requester is visited last, giving it lowest priority.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = last + IDXW'(k);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign gnt_vld  = (state == ST_GRANT);
   // done and a dropped owner request in the same cycle are one release.
   assign rel_norm = done || !req[gnt_idx];
   assign rel      = rel_norm || hold_exp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         gnt_idx <= '0;
         last    <= LAST_RST;
      end else begin
         case (state)
            ST_IDLE: begin
               // done is ignored here; only req matters.
               if (pick_vld) begin
                  state   <= ST_GRANT;
                  gnt_idx <= pick_idx;
               end
            end
            ST_GRANT: begin
               if (rel) begin
                  state <= ST_IDLE;
                  last  <= gnt_idx;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_RR_8_TIMEOUT_EN
   // hold_cnt counts completed GRANT cycles of the current owner; the grant
   // is released at the edge ending its MAX_HOLD-th cycle.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
   logic       timeout_r;

   assign hold_exp = gnt_vld && (hold_cnt == HOLD_LAST);
   assign timeout  = timeout_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         // Held at zero in IDLE, so every GRANT entry starts from zero.
         if (!gnt_vld)
            hold_cnt <= '0;
         else if (!rel)
            hold_cnt <= hold_cnt + 8'd1;
         // A normal release in the same cycle wins; no timeout reported.
         timeout_r <= hold_exp && !rel_norm;
      end
   end
`else
   assign hold_exp = 1'b0;
   assign timeout  = 1'b0;
`endif

   dcd_3_to_8 u_dcd (
      .idx  (gnt_idx),
      .en   (gnt_vld),
      .dout (gnt)
   );

endmodule
